// File: rtl/wbrr_arbiter.sv
// Round-robin N-master to 1-slave Wishbone arbiter with zero-latency grant from IDLE.
// Optional bus-stall watchdog and ABORT state enabled by defining WBRR_TIMEOUT_EN.
module wbrr_arbiter #(
    parameter int NM      = 4,
    parameter int DW      = 32,
    parameter int AW      = 19,
    parameter int TIMEOUT = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NM-1:0]        i_cyc,
    input  logic [NM-1:0]        i_stb,
    input  logic [NM-1:0]        i_we,
    input  logic [NM*AW-1:0]     i_adr,
    input  logic [NM*DW-1:0]     i_dat,
    input  logic [NM*DW/8-1:0]   i_sel,
    output logic [NM-1:0]        o_ack,
    output logic [NM-1:0]        o_stall,
    output logic [NM-1:0]        o_err,
    output logic                 o_cyc,
    output logic                 o_stb,
    output logic                 o_we,
    output logic [AW-1:0]        o_adr,
    output logic [DW-1:0]        o_dat,
    output logic [DW/8-1:0]      o_sel,
    input  logic                 i_ack,
    input  logic                 i_stall,
    input  logic                 i_err,
    output logic [NM-1:0]        o_grant
);
    localparam int IW = $clog2(NM);
    localparam int SW = DW / 8;

    if (NM < 2 || NM > 16) begin : g_bad_nm
        $error("wbrr_arbiter: NM must be within 2..16");
    end
    if (DW % 8 != 0) begin : g_bad_dw
        $error("wbrr_arbiter: DW must be a multiple of 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wbrr_arbiter: TIMEOUT must be within 1..65535");
    end

`ifdef WBRR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ABORT} state_t;
    logic [CW-1:0] r_cnt, w_cnt_nx;
`else
    typedef enum logic {S_IDLE, S_BUSY} state_t;
`endif

    state_t        r_state, w_state_nx;
    logic [IW-1:0] r_owner, w_owner_nx;
    logic [IW-1:0] r_last, w_last_nx;
    logic          r_hold, w_hold_nx;
    logic [IW-1:0] w_sel;
    logic          w_any;
    logic [IW-1:0] w_idx;
    logic          w_own;
    logic          w_tout;

    // Round-robin search upward from the master after the last owner.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int unsigned k = 1; k <= NM; k++) begin
            if (!w_any && i_cyc[(32'(r_last) + k) % NM]) begin
                w_any = 1'b1;
                w_sel = IW'((32'(r_last) + k) % NM);
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        w_hold_nx  = 1'b0;
        w_own      = 1'b0;
        w_idx      = r_owner;
        w_tout     = 1'b0;
`ifdef WBRR_TIMEOUT_EN
        w_cnt_nx   = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_hold && w_any) begin
                    w_own      = 1'b1;
                    w_idx      = w_sel;
                    w_state_nx = S_BUSY;
                    w_owner_nx = w_sel;
                    w_last_nx  = w_sel;
`ifdef WBRR_TIMEOUT_EN
                    w_cnt_nx   = '0;
`endif
                end
            end
            S_BUSY: begin
                if (i_cyc[r_owner]) begin
                    w_own = 1'b1;
`ifdef WBRR_TIMEOUT_EN
                    if (i_ack || i_err) begin
                        w_cnt_nx = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                        if (r_cnt == CW'(TIMEOUT - 1)) begin
                            w_tout     = 1'b1;
                            w_state_nx = S_ABORT;
                        end
                    end
`endif
                end else begin
                    w_state_nx = S_IDLE;
                    w_hold_nx  = 1'b1;
                end
            end
`ifdef WBRR_TIMEOUT_EN
            // The exit clock itself serves as the mandatory bus-idle clock.
            S_ABORT: begin
                if (!i_cyc[r_owner]) begin
                    w_state_nx = S_IDLE;
                end
            end
`endif
            default: w_state_nx = S_IDLE;
        endcase
        // Gate the combinational grant so reset releases the bus immediately.
        if (!i_rst_n) begin
            w_own  = 1'b0;
            w_tout = 1'b0;
        end
    end

    always_comb begin
        o_cyc   = w_own;
        o_stb   = 1'b0;
        o_grant = '0;
        o_ack   = '0;
        o_err   = '0;
        o_stall = '1;
        o_we    = i_we[0];
        o_adr   = i_adr[0 +: AW];
        o_dat   = i_dat[0 +: DW];
        o_sel   = i_sel[0 +: SW];
        for (int unsigned m = 0; m < NM; m++) begin
            if (w_own && w_idx == IW'(m)) begin
                o_grant[m] = 1'b1;
                o_ack[m]   = i_ack;
                o_err[m]   = i_err | w_tout;
                o_stall[m] = i_stall;
                o_stb      = i_stb[m];
                o_we       = i_we[m];
                o_adr      = i_adr[m*AW +: AW];
                o_dat      = i_dat[m*DW +: DW];
                o_sel      = i_sel[m*SW +: SW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= IW'(NM - 1);
            r_hold  <= 1'b0;
`ifdef WBRR_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_hold  <= w_hold_nx;
`ifdef WBRR_TIMEOUT_EN
            r_cnt   <= w_cnt_nx;
`endif
        end
    end
endmodule

// File: tb/tb_wbrr_arbiter.sv
// Directed self-checking bench for wbrr_arbiter (NM=4, DW=32, AW=19, TIMEOUT=8).
module tb_wbrr_arbiter;
    localparam int NM = 4;
    localparam int DW = 32;
    localparam int AW = 19;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     cyc, stb, we;
    logic [NM*AW-1:0]  adr;
    logic [NM*DW-1:0]  dat;
    logic [NM*DW/8-1:0] sel;
    logic [NM-1:0]     ack_o, stall_o, err_o, grant_o;
    logic              cyc_o, stb_o, we_o;
    logic [AW-1:0]     adr_o;
    logic [DW-1:0]     dat_o;
    logic [DW/8-1:0]   sel_o;
    logic              s_ack, s_stall, s_err;

    int n_tests = 0;
    int n_fail  = 0;

    wbrr_arbiter #(.NM(NM), .DW(DW), .AW(AW), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_adr(adr), .i_dat(dat), .i_sel(sel),
        .o_ack(ack_o), .o_stall(stall_o), .o_err(err_o),
        .o_cyc(cyc_o), .o_stb(stb_o), .o_we(we_o), .o_adr(adr_o), .o_dat(dat_o), .o_sel(sel_o),
        .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err),
        .o_grant(grant_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 4'b0101; stb = 4'b0101; we = 4'b0110;
        s_ack = 1'b1; s_stall = 1'b1; s_err = 1'b0;
        for (int m = 0; m < NM; m++) begin
            adr[m*AW +: AW] = AW'(32'h1000 + m);
            dat[m*DW +: DW] = 32'hD000_0000 + 32'(m);
            sel[m*4 +: 4]   = 4'(m + 1);
        end
        #2;
        chk("rst_cyc",   64'(cyc_o),   64'h0);
        chk("rst_stb",   64'(stb_o),   64'h0);
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_ack",   64'(ack_o),   64'h0);
        chk("rst_err",   64'(err_o),   64'h0);
        chk("rst_stall", 64'(stall_o), 64'hF);
        tick(); tick();

        // Release with masters 0 and 2 requesting: master 0 granted at once.
        s_ack = 1'b0;
        rst_n = 1'b1;
        #2;
        chk("g0_grant", 64'(grant_o), 64'h1);
        chk("g0_cyc",   64'(cyc_o),   64'h1);
        chk("g0_stb",   64'(stb_o),   64'h1);
        chk("g0_adr",   64'(adr_o),   64'h1000);
        tick(); #2;
        chk("g0_hold", 64'(grant_o), 64'h1);
        tick(); cyc = 4'b0100; #2;
        chk("g0_drop_cyc",   64'(cyc_o),   64'h0);
        chk("g0_drop_grant", 64'(grant_o), 64'h0);
        tick(); #2;
        chk("idle_clk_cyc",   64'(cyc_o),   64'h0);
        chk("idle_clk_grant", 64'(grant_o), 64'h0);
        tick(); #2;
        chk("g2_grant", 64'(grant_o), 64'h4);
        chk("g2_cyc",   64'(cyc_o),   64'h1);

        // Master 2 owns: slave responses routed only to it.
        tick(); s_ack = 1'b1; s_stall = 1'b0; #2;
        chk("g2_ack",   64'(ack_o),   64'h4);
        chk("g2_stall", 64'(stall_o), 64'hB);
        chk("g2_adr",   64'(adr_o),   64'h1002);
        chk("g2_dat",   64'(dat_o),   64'hD000_0002);
        chk("g2_sel",   64'(sel_o),   64'h3);
        chk("g2_we",    64'(we_o),    64'h1);
        chk("g2_stb",   64'(stb_o),   64'h1);
        tick(); s_ack = 1'b0; s_err = 1'b1; #2;
        chk("g2_err", 64'(err_o), 64'h4);
        s_err = 1'b0; s_stall = 1'b1;

        // Owner drops while slave stalls and master 1 waits.
        tick(); cyc = 4'b0010; stb = 4'b0010; #2;
        chk("drop_stall_cyc",   64'(cyc_o),   64'h0);
        chk("drop_stall_grant", 64'(grant_o), 64'h0);
        chk("drop_stall_stall", 64'(stall_o), 64'hF);
        tick(); #2;
        chk("drop_stall_idle", 64'(cyc_o), 64'h0);
        tick(); #2;
        chk("g1_grant", 64'(grant_o), 64'h2);
        tick(); cyc = 4'b0000; #2;
        chk("g1_drop", 64'(cyc_o), 64'h0);
        tick(); tick(); cyc = 4'b1000; stb = 4'b1000; #2;
        chk("g3_grant", 64'(grant_o), 64'h8);

        // Mid-cycle reset releases the bus asynchronously.
        tick(); s_ack = 1'b1; #2;
        chk("g3_ack", 64'(ack_o), 64'h8);
        rst_n = 1'b0;
        #1;
        chk("arst_cyc",   64'(cyc_o),   64'h0);
        chk("arst_grant", 64'(grant_o), 64'h0);
        chk("arst_ack",   64'(ack_o),   64'h0);
        tick(); s_ack = 1'b0;

        // All masters request; each owner holds 3 clocks then drops for one.
        cyc = 4'b1111; stb = 4'b1111;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            #2;
            chk("rr_grant", 64'(grant_o), 64'(exp_g));
            chk("rr_cyc",   64'(cyc_o),   64'h1);
            if (k < 4) begin
                tick(); #2;
                chk("rr_hold1", 64'(grant_o), 64'(exp_g));
                tick(); #2;
                chk("rr_hold2", 64'(grant_o), 64'(exp_g));
                tick(); cyc = ~exp_g; #2;
                chk("rr_drop_cyc", 64'(cyc_o), 64'h0);
                tick(); cyc = 4'b1111; #2;
                chk("rr_idle_cyc", 64'(cyc_o), 64'h0);
                tick();
            end
        end

        // Lone requester is re-granted after the idle clock.
        tick(); cyc = 4'b0000; #2;
        chk("solo_drop", 64'(cyc_o), 64'h0);
        tick(); cyc = 4'b0001; #2;
        chk("solo_idle", 64'(cyc_o), 64'h0);
        tick(); #2;
        chk("solo_grant", 64'(grant_o), 64'h1);

`ifdef WBRR_TIMEOUT_EN
        // Slave never acks: error pulse on the 8th BUSY clock, then ABORT.
        for (int b = 1; b <= 8; b++) begin
            tick(); #2;
            chk("to_err",  64'(err_o), (b == 8) ? 64'h1 : 64'h0);
            chk("to_cyc",  64'(cyc_o), 64'h1);
        end
        tick(); s_ack = 1'b1; #2;
        chk("abort_cyc",   64'(cyc_o),   64'h0);
        chk("abort_grant", 64'(grant_o), 64'h0);
        chk("abort_stall", 64'(stall_o), 64'hF);
        chk("abort_ack",   64'(ack_o),   64'h0);
        chk("abort_err",   64'(err_o),   64'h0);
        tick(); s_ack = 1'b0; #2;
        chk("abort_wait", 64'(cyc_o), 64'h0);
        tick(); cyc = 4'b0010; #2;
        chk("abort_exit", 64'(cyc_o), 64'h0);
        tick(); #2;
        chk("post_abort_grant", 64'(grant_o), 64'h2);
`else
        // Without the watchdog a stalled owner keeps the bus indefinitely.
        for (int b = 1; b <= 20; b++) begin
            tick(); #2;
            chk("nto_err",   64'(err_o),   64'h0);
            chk("nto_grant", 64'(grant_o), 64'h1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
